// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants, types and helpers for the integer register file.
//   XLEN       - default register width
//   REG_ADDR_W - default register address width
//   xlen_t, reg_addr_t - data / address types at the default sizes
//   reg_is_zero()      - true for the hardwired-zero register x0
package gpr_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic reg_is_zero(input reg_addr_t addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/gpr_multiport_if.sv
// gpr_multiport_if: bundle of read, writeback and reservation signals of the
// register file. Suffixes _i/_o are seen from the register file.
//   rs_*            - NUM_RD combinational read ports with busy lookup
//   wr_*            - NUM_WR writeback ports
//   rsv_*           - destination reservation handshake
//   busy_o          - registered busy vector
//   wr_collision_o  - sticky same-address multi-write error
// Modports: slave = register file, master = issue/writeback side.
interface gpr_multiport_if #(
    parameter int unsigned DATA_WIDTH = gpr_pkg::XLEN,
    parameter int unsigned RF_SIZE    = gpr_pkg::REG_ADDR_W,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1
);

    logic [NUM_RD*RF_SIZE-1:0]    rs_addr_i;
    logic [NUM_RD*DATA_WIDTH-1:0] rs_data_o;
    logic [NUM_RD-1:0]            rs_busy_o;
    logic [NUM_WR-1:0]            wr_en_i;
    logic [NUM_WR*RF_SIZE-1:0]    wr_addr_i;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i;
    logic                         rsv_valid_i;
    logic [RF_SIZE-1:0]           rsv_addr_i;
    logic                         rsv_ready_o;
    logic [(2**RF_SIZE)-1:0]      busy_o;
    logic                         wr_collision_o;

    modport slave (
        input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_valid_i, rsv_addr_i,
        output rs_data_o, rs_busy_o, rsv_ready_o, busy_o, wr_collision_o
    );

    modport master (
        output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_valid_i, rsv_addr_i,
        input  rs_data_o, rs_busy_o, rsv_ready_o, busy_o, wr_collision_o
    );

endinterface

// File: rtl/gpr_busy_table.sv
// gpr_busy_table: per-register scoreboard.
//   clk, rst_n   - clock, synchronous active-low reset
//   wr_mask_i    - one bit per register written this cycle (x0 never set)
//   rsv_valid_i  - reservation request
//   rsv_addr_i   - destination to reserve
//   rs_addr_i    - read-port source addresses for the busy lookup
//   rsv_ready_o  - reservation accepted
//   rs_busy_o    - source still reserved after this cycle's writebacks
//   busy_o       - registered busy vector, bit 0 always 0
module gpr_busy_table #(
    parameter int unsigned RF_SIZE = 5,
    parameter int unsigned NUM_RD  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(2**RF_SIZE)-1:0]   wr_mask_i,
    input  logic                      rsv_valid_i,
    input  logic [RF_SIZE-1:0]        rsv_addr_i,
    input  logic [NUM_RD*RF_SIZE-1:0] rs_addr_i,
    output logic                      rsv_ready_o,
    output logic [NUM_RD-1:0]         rs_busy_o,
    output logic [(2**RF_SIZE)-1:0]   busy_o
);

    logic [(2**RF_SIZE)-1:0] busy_q;
    logic [(2**RF_SIZE)-1:0] busy_d;
    logic                    rsv_ready;

    always_comb begin
        rsv_ready = rst_n && ((rsv_addr_i == '0) || !busy_q[rsv_addr_i]
                              || wr_mask_i[rsv_addr_i]);

        // Clear on writeback first, then set: a same-cycle reservation wins.
        busy_d = busy_q & ~wr_mask_i;
        if (rsv_valid_i && rsv_ready && (rsv_addr_i != '0)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        rs_busy_o = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rs_busy_o[i] = (rs_addr_i[i*RF_SIZE +: RF_SIZE] != '0)
                           && busy_q[rs_addr_i[i*RF_SIZE +: RF_SIZE]]
                           && !wr_mask_i[rs_addr_i[i*RF_SIZE +: RF_SIZE]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rsv_ready_o = rsv_ready;
    assign busy_o      = busy_q;

endmodule

// File: rtl/gpr_multiport.sv
// gpr_multiport: multi-port integer register file with write-first bypass,
// hardwired x0, sticky write-collision flag and a reservation scoreboard.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - gpr_multiport_if.slave: read ports, writeback ports,
//                reservation handshake, busy vector, collision flag
module gpr_multiport
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned RF_SIZE    = REG_ADDR_W,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    gpr_multiport_if.slave bus
);

    localparam int unsigned NUM_REGS = 2**RF_SIZE;

    logic [DATA_WIDTH-1:0]        regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]        regs_d [NUM_REGS];
    logic                         collision_q;
    logic                         collision_d;
    logic [NUM_WR-1:0]            wr_hit;
    logic [NUM_REGS-1:0]          wr_mask;
    logic [NUM_RD*DATA_WIDTH-1:0] rs_data;

    // Effective writes: enabled, nonzero address, not in reset.
    always_comb begin
        wr_hit  = '0;
        wr_mask = '0;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (rst_n && bus.wr_en_i[k]
                && (bus.wr_addr_i[k*RF_SIZE +: RF_SIZE] != '0)) begin
                wr_hit[k] = 1'b1;
                wr_mask[bus.wr_addr_i[k*RF_SIZE +: RF_SIZE]] = 1'b1;
            end
        end
    end

    // Ascending port order makes the highest-index port win a clash.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_hit[k]) begin
                regs_d[bus.wr_addr_i[k*RF_SIZE +: RF_SIZE]] =
                    bus.wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        regs_d[0] = '0;
    end

    always_comb begin
        collision_d = collision_q;
        for (int unsigned j = 1; j < NUM_WR; j++) begin
            for (int unsigned k = 0; k < j; k++) begin
                if (wr_hit[j] && wr_hit[k]
                    && (bus.wr_addr_i[j*RF_SIZE +: RF_SIZE]
                        == bus.wr_addr_i[k*RF_SIZE +: RF_SIZE])) begin
                    collision_d = 1'b1;
                end
            end
        end
    end

    // Write-first read: latest matching enabled write port overrides storage.
    always_comb begin
        rs_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (bus.rs_addr_i[i*RF_SIZE +: RF_SIZE] != '0) begin
                rs_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    regs_q[bus.rs_addr_i[i*RF_SIZE +: RF_SIZE]];
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if (wr_hit[k] && (bus.wr_addr_i[k*RF_SIZE +: RF_SIZE]
                                      == bus.rs_addr_i[i*RF_SIZE +: RF_SIZE])) begin
                        rs_data[i*DATA_WIDTH +: DATA_WIDTH] =
                            bus.wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            collision_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            collision_q <= collision_d;
        end
    end

    assign bus.rs_data_o      = rs_data;
    assign bus.wr_collision_o = collision_q;

    gpr_busy_table #(
        .RF_SIZE (RF_SIZE),
        .NUM_RD  (NUM_RD)
    ) u_busy_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_mask_i   (wr_mask),
        .rsv_valid_i (bus.rsv_valid_i),
        .rsv_addr_i  (bus.rsv_addr_i),
        .rs_addr_i   (bus.rs_addr_i),
        .rsv_ready_o (bus.rsv_ready_o),
        .rs_busy_o   (bus.rs_busy_o),
        .busy_o      (bus.busy_o)
    );

endmodule

// File: tb/tb_gpr_multiport.sv
// tb_gpr_multiport: directed self-checking bench for gpr_multiport with
// two read ports and two write ports.
module tb_gpr_multiport;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    gpr_multiport_if #(
        .DATA_WIDTH (64),
        .RF_SIZE    (5),
        .NUM_RD     (2),
        .NUM_WR     (2)
    ) bus ();

    gpr_multiport #(
        .DATA_WIDTH (64),
        .RF_SIZE    (5),
        .NUM_RD     (2),
        .NUM_WR     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rs_addr_i   = '0;
        bus.wr_en_i     = '0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;
        bus.rsv_valid_i = 1'b0;
        bus.rsv_addr_i  = '0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        bus.rs_addr_i[p*5 +: 5] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [63:0] d);
        bus.wr_en_i[p]           = en;
        bus.wr_addr_i[p*5 +: 5]  = a;
        bus.wr_data_i[p*64 +: 64] = d;
    endtask

    task automatic set_rsv(input logic v, input logic [4:0] a);
        bus.rsv_valid_i = v;
        bus.rsv_addr_i  = a;
    endtask

    function automatic logic [63:0] rd(input int p);
        return bus.rs_data_o[p*64 +: 64];
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle();

        // Reset held for two edges, with a reservation request pending.
        set_rsv(1'b1, 5'd4);
        #1;
        check("rsv_ready_in_reset", {63'd0, bus.rsv_ready_o}, 64'd0);
        tick();
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        for (int r = 1; r < 32; r++) begin
            set_rd(0, 5'(r));
            set_rd(1, 5'(r));
            #1;
            check("reset_read_p0", rd(0), 64'd0);
            check("reset_read_p1", rd(1), 64'd0);
        end
        check("reset_busy", {32'd0, bus.busy_o}, 64'd0);
        check("reset_collision", {63'd0, bus.wr_collision_o}, 64'd0);

        // x0 immunity: both ports write x0, reserve x0.
        idle();
        set_wr(0, 1'b1, 5'd0, 64'hDEAD);
        set_wr(1, 1'b1, 5'd0, 64'hBEEF);
        set_rsv(1'b1, 5'd0);
        #1;
        check("x0_read_same", rd(0), 64'd0);
        check("x0_rsv_ready", {63'd0, bus.rsv_ready_o}, 64'd1);
        tick();
        idle();
        #1;
        check("x0_read_next", rd(0), 64'd0);
        check("x0_busy", {32'd0, bus.busy_o}, 64'd0);
        check("x0_no_collision", {63'd0, bus.wr_collision_o}, 64'd0);

        // Write-first bypass with a port clash on x5, plus x6 on read port 1.
        set_wr(0, 1'b1, 5'd5, 64'h11);
        set_wr(1, 1'b1, 5'd5, 64'h22);
        set_rd(0, 5'd5);
        #1;
        check("bypass_clash", rd(0), 64'h22);
        check("collision_not_yet", {63'd0, bus.wr_collision_o}, 64'd0);
        tick();
        idle();
        set_rd(0, 5'd5);
        #1;
        check("x5_stored", rd(0), 64'h22);
        check("collision_set", {63'd0, bus.wr_collision_o}, 64'd1);
        set_wr(0, 1'b1, 5'd6, 64'hAAAA_0000_5555_FFFF);
        set_rd(1, 5'd6);
        #1;
        check("bypass_p1", rd(1), 64'hAAAA_0000_5555_FFFF);
        check("x5_unaffected", rd(0), 64'h22);
        tick();
        idle();
        set_rd(1, 5'd6);
        #1;
        check("x6_stored", rd(1), 64'hAAAA_0000_5555_FFFF);
        check("collision_sticky", {63'd0, bus.wr_collision_o}, 64'd1);

        // Scoreboard on x7.
        set_rsv(1'b1, 5'd7);
        #1;
        check("rsv7_ready", {63'd0, bus.rsv_ready_o}, 64'd1);
        tick();
        #1;
        check("busy7_set", {32'd0, bus.busy_o}, 64'h80);
        check("rsv7_again_ready", {63'd0, bus.rsv_ready_o}, 64'd0);
        set_rd(0, 5'd7);
        #1;
        check("rs_busy7", {63'd0, bus.rs_busy_o[0]}, 64'd1);
        tick();
        #1;
        check("busy7_hold", {32'd0, bus.busy_o}, 64'h80);
        set_rsv(1'b0, 5'd7);
        set_wr(1, 1'b1, 5'd7, 64'h5);
        #1;
        check("rs_busy7_wr", {63'd0, bus.rs_busy_o[0]}, 64'd0);
        check("x7_bypass", rd(0), 64'h5);
        check("rsv7_ready_wr", {63'd0, bus.rsv_ready_o}, 64'd1);
        tick();
        idle();
        set_rd(0, 5'd7);
        #1;
        check("busy7_clear", {32'd0, bus.busy_o}, 64'd0);
        check("x7_stored", rd(0), 64'h5);

        // Same-cycle reservation is invisible to rs_busy_o.
        set_rsv(1'b1, 5'd8);
        set_rd(1, 5'd8);
        #1;
        check("rs_busy8_same", {63'd0, bus.rs_busy_o[1]}, 64'd0);
        tick();
        set_rsv(1'b0, 5'd0);
        #1;
        check("rs_busy8_next", {63'd0, bus.rs_busy_o[1]}, 64'd1);
        check("busy8", {32'd0, bus.busy_o}, 64'h100);

        // Simultaneous clear and reserve on x9.
        idle();
        set_rsv(1'b1, 5'd9);
        tick();
        #1;
        check("busy89", {32'd0, bus.busy_o}, 64'h300);
        set_wr(0, 1'b1, 5'd9, 64'hA);
        #1;
        check("rsv9_ready_wr", {63'd0, bus.rsv_ready_o}, 64'd1);
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        check("busy9_kept", {32'd0, bus.busy_o}, 64'h300);
        check("x9_stored", rd(0), 64'hA);
        check("rs_busy9", {63'd0, bus.rs_busy_o[0]}, 64'd1);

        // Reset in the middle of activity.
        set_wr(0, 1'b1, 5'd3, 64'h77);
        tick();
        idle();
        set_rsv(1'b1, 5'd3);
        tick();
        idle();
        set_rd(0, 5'd3);
        #1;
        check("x3_pre", rd(0), 64'h77);
        check("busy_pre", {32'd0, bus.busy_o}, 64'h308);
        rst_n = 1'b0;
        set_wr(1, 1'b1, 5'd3, 64'h99);
        set_rsv(1'b1, 5'd10);
        #1;
        check("rst_no_bypass", rd(0), 64'h77);
        check("rst_rsv_ready", {63'd0, bus.rsv_ready_o}, 64'd0);
        tick();
        #1;
        check("rst_x3", rd(0), 64'd0);
        check("rst_busy", {32'd0, bus.busy_o}, 64'd0);
        check("rst_collision", {63'd0, bus.wr_collision_o}, 64'd0);
        check("rst_rsv_ready2", {63'd0, bus.rsv_ready_o}, 64'd0);
        idle();
        rst_n = 1'b1;
        set_rd(0, 5'd3);
        set_rd(1, 5'd5);
        #1;
        check("post_x3", rd(0), 64'd0);
        check("post_x5", rd(1), 64'd0);
        tick();
        #1;
        check("post_busy", {32'd0, bus.busy_o}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpr_multiport.md
Name: gpr_multiport

Overview:
Parametrised integer register file for the pipelined/superscalar core. It has NUM_RD read ports and NUM_WR write ports, with write-first bypass and x0 hardwired to zero. A per-register busy table (scoreboard) tracks destinations reserved at issue and releases them at writeback. Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH, 64, register width in bits
RF_SIZE, 5, address width; 2**RF_SIZE registers
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
rs_addr_i  in  NUM_RD*RF_SIZE  read addresses; port i in slice i
rs_data_o  out  NUM_RD*DATA_WIDTH  read data, combinational
rs_busy_o  out  NUM_RD  1 = source still reserved after this cycle's writebacks
wr_en_i  in  NUM_WR  writeback enable per port
wr_addr_i  in  NUM_WR*RF_SIZE  writeback addresses
wr_data_i  in  NUM_WR*DATA_WIDTH  writeback data
rsv_valid_i  in  1  request to reserve a destination
rsv_addr_i  in  RF_SIZE  destination to reserve
rsv_ready_o  out  1  reservation accepted this cycle when high with rsv_valid_i
busy_o  out  2**RF_SIZE  registered busy vector; bit 0 is always 0
wr_collision_o  out  1  sticky error: two or more enabled write ports hit the same nonzero address in one cycle

Behaviour:
- Reset: when rst_n is low at a posedge, all registers go to 0, busy_o goes to 0, and wr_collision_o goes to 0. While rst_n is low, writes and reservations are ignored, the bypass is disabled, and rsv_ready_o is 0.
- Write: on a posedge with wr_en_i[k] and addr != 0, the register takes wr_data_i[k]. On an address clash between ports, the highest-index port wins. A clash sets wr_collision_o on the next cycle; it holds until reset.
- Writes to x0 are dropped. They never set, clear or collide.
- Read (combinational, write-first):
  - addr 0 reads 0.
  - Otherwise, if any enabled write port matches the address, the read returns that port's data (highest matching index).
  - Otherwise the read returns stored data.
- Busy clear: an enabled write to a busy register clears its bit at the posedge. A write to a non-busy register is legal and simply writes.
- Reservation handshake:
  - rsv_ready_o = rst_n && (rsv_addr_i == 0 || !busy[rsv_addr_i] || a write to rsv_addr_i this cycle).
  - On a handshake with nonzero addr, busy[addr] is set at the posedge.
  - If a write-clear and a reservation hit the same register in the same cycle, the reservation wins and the bit stays 1.
  - Reserving x0 is always accepted and has no effect.
- rs_busy_o[i] = busy[addr] && no enabled write to addr this cycle. It is 0 for addr 0. A same-cycle reservation does not affect rs_busy_o (one-cycle visibility through busy_o).
- Latency: read and bypass 0 cycles; writes, busy and the error flag 1 cycle.
- No width arithmetic. Data is stored and forwarded unmodified.

Decomposition:
- gpr_pkg holds:
  - default constants XLEN=64 and REG_ADDR_W=5;
  - typedefs xlen_t and reg_addr_t;
  - the function reg_is_zero(reg_addr_t).
- Sub-module gpr_busy_table (busy vector, reservation handshake, clear/set priority, rs_busy lookup) is instantiated once. Storage, bypass mux and collision detection stay in gpr_multiport.

Test Plan:
- Reset then read: hold rst_n low 2 cycles, release, read x1..x31 -> all 0; busy_o=0; wr_collision_o=0.
- Write-first bypass: NUM_WR=2, same cycle write port0 x5=0x11, port1 x5=0x22, rs_addr x5 -> rs_data 0x22 that cycle. Next cycle x5 reads 0x22 and wr_collision_o=1.
- x0 immunity: write x0=0xDEAD with rsv x0 -> rs_data for x0 is 0 same and next cycle; busy_o[0]=0; rsv_ready_o=1; no collision.
- Scoreboard: reserve x7 -> busy_o[7]=1 next cycle. Re-reserve x7 -> rsv_ready_o=0. Read x7 -> rs_busy_o=1. Write x7=0x5 -> same cycle rs_busy_o=0 and rs_data=0x5; next cycle busy_o[7]=0.
- Simultaneous clear and reserve: x9 busy, write x9=0xA and reserve x9 same cycle -> rsv_ready_o=1, x9 holds 0xA, busy_o[9]=1 next cycle.
- Reset mid-operation: x3 busy and holding 0x77; assert rst_n low while wr_en x3=0x99 -> after the edge x3=0, busy_o=0, and rsv_ready_o=0 throughout reset.
